// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder.
// Latches two DIGITS-digit operands on Start, then adds one decimal digit per
// clock (least significant first) with decimal correction and a registered
// ripple carry. Flags operand digits greater than 9 on Invalid.
// Optional feature macro: BCD_SUB_EN adds the Sub port and ten's-complement
// subtraction (A + nines-complement(B) + 1).
//
// Handshake: Start is sampled only while IDLE (Busy low); the accepting edge
// latches A/B(/Sub), after which the inputs may change. Busy stays high for
// exactly DIGITS cycles; Done pulses for one cycle when Sum/Cout/Invalid are
// valid. Start during Busy is ignored. fsm_state exposes the FSM for checkers.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
`ifdef BCD_SUB_EN
    input  logic                  Sub,
`endif
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  Invalid,
    output logic [0:0]            fsm_state
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]          state;
    logic [4*DIGITS-1:0] a_sh;
    logic [4*DIGITS-1:0] b_sh;
    logic                carry;
    logic [IDX_W-1:0]    idx;
`ifdef BCD_SUB_EN
    logic                sub_q;
`endif

    logic [3:0] a_dig;
    logic [3:0] b_raw;
    logic [3:0] b_eff;
    logic [4:0] t;
    logic [3:0] sum_digit;
    logic       carry_next;
    logic       digit_bad;
    logic       last;

    // Current digit: operands are shifted right so digit 0 is always the active one.
    always_comb begin
        a_dig = a_sh[3:0];
        b_raw = b_sh[3:0];
`ifdef BCD_SUB_EN
        b_eff = sub_q ? (4'd9 - b_raw) : b_raw;
`else
        b_eff = b_raw;
`endif
        t          = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
        sum_digit  = t[3:0];
        carry_next = 1'b0;
        if (t > 5'd9) begin
            sum_digit  = t[3:0] + 4'd6;
            carry_next = 1'b1;
        end
        digit_bad = (a_dig > 4'd9) || (b_raw > 4'd9);
        last      = (idx == IDX_W'(DIGITS - 1));
    end

    // Busy is simply "in RUN"; the state register is exported for observation.
    always_comb begin
        Busy      = (state == RUN);
        fsm_state = state;
    end

    // FSM, operand capture and per-digit accumulation.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            Done    <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Invalid <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        idx     <= '0;
                        Sum     <= '0;
                        Cout    <= 1'b0;
                        Invalid <= 1'b0;
`ifdef BCD_SUB_EN
                        sub_q   <= Sub;
                        carry   <= Sub;
`else
                        carry   <= 1'b0;
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IDX_W'(i)) begin
                            Sum[i*4 +: 4] <= sum_digit;
                        end
                    end
                    carry   <= carry_next;
                    Invalid <= Invalid | digit_bad;
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        Cout  <= carry_next;
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: three instances (2, 4 and 16 digits) driven by
// directed and random operands, checked against an integer-arithmetic model.
module tb_bcd_serial_adder;

    logic        clk;
    logic        rst;
    logic        start2, start4, start16;
    logic [63:0] a_drv, b_drv;
`ifdef BCD_SUB_EN
    logic        sub_drv;
`endif

    logic        busy2, done2, cout2, inv2;
    logic [7:0]  sum2;
    logic [0:0]  st2;
    logic        busy4, done4, cout4, inv4;
    logic [15:0] sum4;
    logic [0:0]  st4;
    logic        busy16, done16, cout16, inv16;
    logic [63:0] sum16;
    logic [0:0]  st16;

    int          sel;
    logic        cur_busy, cur_done, cur_cout, cur_inv;
    logic [63:0] cur_sum;
    logic [0:0]  cur_st;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];

    bcd_serial_adder #(.DIGITS(2)) u2 (
        .Clock(clk), .Reset(rst), .Start(start2), .A(a_drv[7:0]), .B(b_drv[7:0]),
`ifdef BCD_SUB_EN
        .Sub(sub_drv),
`endif
        .Busy(busy2), .Done(done2), .Sum(sum2), .Cout(cout2), .Invalid(inv2), .fsm_state(st2)
    );

    bcd_serial_adder #(.DIGITS(4)) u4 (
        .Clock(clk), .Reset(rst), .Start(start4), .A(a_drv[15:0]), .B(b_drv[15:0]),
`ifdef BCD_SUB_EN
        .Sub(sub_drv),
`endif
        .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4), .Invalid(inv4), .fsm_state(st4)
    );

    bcd_serial_adder #(.DIGITS(16)) u16 (
        .Clock(clk), .Reset(rst), .Start(start16), .A(a_drv), .B(b_drv),
`ifdef BCD_SUB_EN
        .Sub(sub_drv),
`endif
        .Busy(busy16), .Done(done16), .Sum(sum16), .Cout(cout16), .Invalid(inv16), .fsm_state(st16)
    );

    // Clock and output selection
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_busy = 1'b0; cur_done = 1'b0; cur_cout = 1'b0; cur_inv = 1'b0;
        cur_sum  = '0;   cur_st   = '0;
        case (sel)
            0: begin cur_busy = busy2;  cur_done = done2;  cur_cout = cout2;  cur_inv = inv2;
                     cur_sum = {56'd0, sum2};  cur_st = st2; end
            1: begin cur_busy = busy4;  cur_done = done4;  cur_cout = cout4;  cur_inv = inv4;
                     cur_sum = {48'd0, sum4};  cur_st = st4; end
            default: begin cur_busy = busy16; cur_done = done16; cur_cout = cout16; cur_inv = inv16;
                     cur_sum = sum16; cur_st = st16; end
        endcase
    end

    // Reference model helpers (plain decimal arithmetic)
    function automatic int dig(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 4 : 16);
    endfunction

    function automatic longint unsigned pow10(input int d);
        longint unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint unsigned from_bcd(input logic [63:0] v, input int d);
        longint unsigned x = 0;
        for (int i = d - 1; i >= 0; i--) x = x * 10 + longint'(v[i*4 +: 4]);
        return x;
    endfunction

    function automatic logic [63:0] to_bcd(input longint unsigned x, input int d);
        logic [63:0] r = '0;
        longint unsigned y = x;
        for (int i = 0; i < d; i++) begin
            r[i*4 +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_bcd(input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic logic has_bad(input logic [63:0] v, input int d);
        logic bad = 1'b0;
        for (int i = 0; i < d; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Driver helpers
    task automatic set_start(input int s, input logic v);
        case (s)
            0: start2 = v;
            1: start4 = v;
            default: start16 = v;
        endcase
    endtask

    // Issues one operation at the current negedge and follows it to Done.
    // Returns at the negedge where Done is seen (the Done cycle).
    task automatic run_op(input int s, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input bit poke);
        int d = dig(s);
        longint unsigned x = from_bcd(a, d);
        longint unsigned y = from_bcd(b, d);
        longint unsigned m = pow10(d);
        logic [63:0] exp_sum;
        logic exp_cout;
        logic exp_inv = has_bad(a, d) || has_bad(b, d);
        int n;
        int busy_n;
        bit got;
        logic [63:0] want;
        if (sub) begin
            exp_cout = (x >= y);
            exp_sum  = (x >= y) ? to_bcd(x - y, d) : to_bcd(m - (y - x), d);
        end else begin
            exp_cout = ((x + y) >= m);
            exp_sum  = to_bcd((x + y) % m, d);
        end
        exp_q.push_back(exp_sum);
        sel = s;
        a_drv = a; b_drv = b;
`ifdef BCD_SUB_EN
        sub_drv = sub;
`endif
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        a_drv = {$urandom, $urandom};
        b_drv = {$urandom, $urandom};
        n = 1; busy_n = 0; got = 0;
        while (!got && n <= 60) begin
            @(negedge clk);
            if (poke) set_start(s, (n == 1) ? 1'b1 : 1'b0);
            if (cur_done) got = 1;
            else begin
                if (cur_busy) busy_n++;
                @(posedge clk);
                n++;
            end
        end
        want = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout d=%0d: no Done within %0d edges, required %0d", d, n, d + 1);
        end else begin
            checks++;
            if (n != d + 1) begin
                errors++;
                $display("FAIL latency d=%0d: got %0d edges, required %0d", d, n, d + 1);
            end
            checks++;
            if (busy_n != d) begin
                errors++;
                $display("FAIL busy_len d=%0d: got %0d cycles, required %0d", d, busy_n, d);
            end
            checks++;
            if (cur_busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done d=%0d: got %b, required 0", d, cur_busy);
            end
            checks++;
            if (cur_inv !== exp_inv) begin
                errors++;
                $display("FAIL invalid d=%0d a=%h b=%h: got %b, required %b", d, a, b, cur_inv, exp_inv);
            end
            if (!exp_inv) begin
                checks++;
                if (cur_sum !== want) begin
                    errors++;
                    $display("FAIL sum d=%0d a=%h b=%h sub=%b: got %h, required %h", d, a, b, sub, cur_sum, want);
                end
                checks++;
                if (cur_cout !== exp_cout) begin
                    errors++;
                    $display("FAIL cout d=%0d a=%h b=%h sub=%b: got %b, required %b", d, a, b, sub, cur_cout, exp_cout);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_sum !== 64'd0 ||
            cur_cout !== 1'b0 || cur_inv !== 1'b0 || cur_st !== 1'b0) begin
            errors++;
            $display("FAIL %s sel=%0d: busy=%b done=%b sum=%h cout=%b inv=%b st=%b, required all 0",
                     tag, sel, cur_busy, cur_done, cur_sum, cur_cout, cur_inv, cur_st);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_zero("reset_held");
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_zero("after_reset");
        end
    endtask

    task automatic test_add_directed();
        @(negedge clk);
        run_op(0, 64'h47, 64'h38, 1'b0, 1'b0);
        @(negedge clk);
        run_op(1, 64'h1234, 64'h8766, 1'b0, 1'b0);
        @(negedge clk);
        run_op(2, 64'h9999999999999999, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_op(0, 64'h99, 64'h99, 1'b0, 1'b0);
        run_op(0, 64'h00, 64'h00, 1'b0, 1'b0);
        run_op(0, 64'h50, 64'h50, 1'b0, 1'b0);
    endtask

    task automatic test_invalid_and_ignored_start();
        logic [63:0] held;
        @(negedge clk);
        run_op(0, 64'hA5, 64'h01, 1'b0, 1'b1);
        held = cur_sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_sum !== held || cur_inv !== 1'b1) begin
                errors++;
                $display("FAIL ignored_start cyc=%0d: done=%b busy=%b sum=%h inv=%b, required 0 0 %h 1",
                         i, cur_done, cur_busy, cur_sum, cur_inv, held);
            end
        end
        run_op(0, 64'h12, 64'h34, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        sel = 1;
        a_drv = 64'h1111; b_drv = 64'h2222;
`ifdef BCD_SUB_EN
        sub_drv = 1'b0;
`endif
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cur_busy !== 1'b1 || cur_sum !== 64'h0003) begin
            errors++;
            $display("FAIL mid_run: busy=%b sum=%h, required 1 0003", cur_busy, cur_sum);
        end
        rst = 1'b1;
        #1;
        check_zero("async_abort");
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 64'h0042, 64'h0058, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                run_op(s, rand_bcd(dig(s)), rand_bcd(dig(s)), 1'b0, 1'b0);
                if ($urandom_range(0, 1) == 0) @(negedge clk);
            end
        end
    endtask

`ifdef BCD_SUB_EN
    task automatic test_subtract();
        @(negedge clk);
        run_op(0, 64'h47, 64'h38, 1'b1, 1'b0);
        run_op(0, 64'h38, 64'h47, 1'b1, 1'b0);
        run_op(0, 64'h25, 64'h25, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 6; k++) begin
                run_op(s, rand_bcd(dig(s)), rand_bcd(dig(s)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0; sel = 0;
        rst = 1'b1; start2 = 1'b0; start4 = 1'b0; start16 = 1'b0;
        a_drv = '0; b_drv = '0;
`ifdef BCD_SUB_EN
        sub_drv = 1'b0;
`endif
        test_reset();
        test_add_directed();
        test_back_to_back();
        test_invalid_and_ignored_start();
        test_reset_mid_run();
        test_random();
`ifdef BCD_SUB_EN
        test_subtract();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
